// File: rtl/small_calculator_core_pkg.sv
// Shared definitions for the small calculator core: FSM state encoding,
// operation codes, register-file write-data selects and the ALU function.
package small_calculator_core_pkg;

    localparam int W = 4;

    // State numbers double as the debug CS encoding; the execute states
    // sit at 4..7 so that the low two bits equal the operation code.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_DECODE = 3'd3,
        S_ADD    = 3'd4,
        S_SUB    = 3'd5,
        S_AND    = 3'd6,
        S_XOR    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    // Register-file write-data source
    typedef enum logic [1:0] {
        S1_ALU  = 2'b00,
        S1_ZERO = 2'b01,
        S1_IN2  = 2'b10,
        S1_IN1  = 2'b11
    } s1_sel_t;

    // Register-file roles: R1 holds operand A, R2 operand B, R3 the result
    localparam logic [1:0] REG_A   = 2'd1;
    localparam logic [1:0] REG_B   = 2'd2;
    localparam logic [1:0] REG_RES = 2'd3;

    // Four-function ALU; all arithmetic wraps modulo 2**W
    function automatic logic [W-1:0] aluCompute(
        input op_t          c,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W-1:0] r;
        case (c)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/small_calculator_core_if.sv
// Request/result bundle of the calculator core. The master issues go/op and
// the operands; the slave (the core) returns the result, state and done.
interface small_calculator_core_if;

    logic       go;
    logic [1:0] op;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] out;
    logic [2:0] CS;
    logic       done;

    modport master (
        output go, op, in1, in2,
        input  out, CS, done
    );

    modport slave (
        input  go, op, in1, in2,
        output out, CS, done
    );

endinterface

// File: rtl/small_calc_ctrl.sv
// Moore control FSM: IDLE -> LOAD_A -> LOAD_B -> DECODE -> one of four
// execute states -> IDLE. Produces every datapath control from the state.
module small_calc_ctrl
    import small_calculator_core_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_go,
    input  logic [1:0] i_op,
    output logic [1:0] o_s1,
    output logic [1:0] o_wa,
    output logic       o_we,
    output logic [1:0] o_raa,
    output logic       o_rea,
    output logic [1:0] o_rab,
    output logic       o_reb,
    output logic [1:0] o_c,
    output logic       o_s2,
    output logic       o_done,
    output logic [2:0] o_cs
);

    state_t r_state;
    state_t w_nextState;

    // State register; reset is sampled on the clock and always wins, so a
    // sequence cut short here never reaches its writeback state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode; everything idles at 0 unless a state
    // asks for it.
    always_comb begin
        w_nextState = r_state;
        o_s1        = S1_ALU;
        o_wa        = 2'd0;
        o_we        = 1'b0;
        o_raa       = 2'd0;
        o_rea       = 1'b0;
        o_rab       = 2'd0;
        o_reb       = 1'b0;
        o_c         = 2'd0;
        o_s2        = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nextState = i_go ? S_LOAD_A : S_IDLE;
            end
            S_LOAD_A: begin
                o_s1        = S1_IN1;
                o_wa        = REG_A;
                o_we        = 1'b1;
                w_nextState = S_LOAD_B;
            end
            S_LOAD_B: begin
                o_s1        = S1_IN2;
                o_wa        = REG_B;
                o_we        = 1'b1;
                w_nextState = S_DECODE;
            end
            S_DECODE: begin
                w_nextState = state_t'({1'b1, i_op});
            end
            S_ADD, S_SUB, S_AND, S_XOR: begin
                o_raa       = REG_A;
                o_rea       = 1'b1;
                o_rab       = REG_B;
                o_reb       = 1'b1;
                o_c         = r_state[1:0];
                o_s2        = 1'b1;
                o_s1        = S1_ALU;
                o_wa        = REG_RES;
                o_we        = 1'b1;
                o_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign o_cs = r_state;

endmodule

// File: rtl/small_calc_path.sv
// Datapath: 4x4 register file with one write and two gated read ports,
// write-data mux, ALU and the output gate.
module small_calc_path
    import small_calculator_core_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_in1,
    input  logic [W-1:0] i_in2,
    input  logic [1:0]   i_s1,
    input  logic [1:0]   i_wa,
    input  logic         i_we,
    input  logic [1:0]   i_raa,
    input  logic         i_rea,
    input  logic [1:0]   i_rab,
    input  logic         i_reb,
    input  logic [1:0]   i_c,
    input  logic         i_s2,
    output logic [W-1:0] o_out
);

    logic [W-1:0] r_rf [4];
    logic [W-1:0] w_readA;
    logic [W-1:0] w_readB;
    logic [W-1:0] w_alu;
    logic [W-1:0] w_wdata;

    // Read ports see the stored contents, so a same-cycle read of the
    // address being written still returns the old value.
    assign w_readA = i_rea ? r_rf[i_raa] : '0;
    assign w_readB = i_reb ? r_rf[i_rab] : '0;
    assign w_alu   = aluCompute(op_t'(i_c), w_readA, w_readB);
    assign o_out   = i_s2 ? w_alu : '0;

    // Write-data source select
    always_comb begin
        w_wdata = '0;
        case (s1_sel_t'(i_s1))
            S1_IN1:  w_wdata = i_in1;
            S1_IN2:  w_wdata = i_in2;
            S1_ZERO: w_wdata = '0;
            default: w_wdata = w_alu;
        endcase
    end

    // Register file storage; reset clears every entry and blocks the write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
        end else if (i_we) begin
            r_rf[i_wa] <= w_wdata;
        end
    end

endmodule

// File: rtl/small_calculator_core.sv
// Calculator compute leaf: joins the control FSM to the datapath and
// exposes the request/result bundle through the interface.
module small_calculator_core
    import small_calculator_core_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    small_calculator_core_if.slave  bus
);

    logic [1:0]   w_s1;
    logic [1:0]   w_wa;
    logic         w_we;
    logic [1:0]   w_raa;
    logic         w_rea;
    logic [1:0]   w_rab;
    logic         w_reb;
    logic [1:0]   w_c;
    logic         w_s2;
    logic         w_done;
    logic [2:0]   w_cs;
    logic [W-1:0] w_out;

    small_calc_ctrl u_ctrl (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_go    (bus.go),
        .i_op    (bus.op),
        .o_s1    (w_s1),
        .o_wa    (w_wa),
        .o_we    (w_we),
        .o_raa   (w_raa),
        .o_rea   (w_rea),
        .o_rab   (w_rab),
        .o_reb   (w_reb),
        .o_c     (w_c),
        .o_s2    (w_s2),
        .o_done  (w_done),
        .o_cs    (w_cs)
    );

    small_calc_path u_path (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_in1   (bus.in1),
        .i_in2   (bus.in2),
        .i_s1    (w_s1),
        .i_wa    (w_wa),
        .i_we    (w_we),
        .i_raa   (w_raa),
        .i_rea   (w_rea),
        .i_rab   (w_rab),
        .i_reb   (w_reb),
        .i_c     (w_c),
        .i_s2    (w_s2),
        .o_out   (w_out)
    );

    assign bus.out  = w_out;
    assign bus.CS   = w_cs;
    assign bus.done = w_done;

endmodule

// File: tb/tb_small_calculator_core.sv
// Self-checking bench for small_calculator_core: stimulus pushes expected
// results into a scoreboard queue, a negedge monitor pops on every done.
module tb_small_calculator_core;

    localparam time PERIOD = 10;

    typedef struct {
        int  res;
        int  cs;
        time t;
    } expect_t;

    logic    clk;
    logic    rst_n;
    bit      monEnable;
    int      checkCount;
    int      errorCount;
    expect_t scoreQ[$];
    expect_t monEntry;

    small_calculator_core_if bus();

    small_calculator_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    // Reference model: the four operations as plain integer arithmetic
    function automatic int refCalc(input int a, input int b, input int o);
        int r;
        case (o)
            0:       r = (a + b) % 16;
            1:       r = (a - b + 16) % 16;
            2:       r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Runs one five-cycle operation frame starting at a negedge. With late
    // set, inputs are disturbed after capture and a stray go is issued; with
    // holdGo set, go stays high for back-to-back launches.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] o, input bit late, input bit holdGo);
        expect_t e;
        bus.in1 = a;
        bus.in2 = b;
        bus.op  = o;
        bus.go  = 1'b1;
        e.res = refCalc(int'(a), int'(b), int'(o));
        e.cs  = 4 + int'(o);
        e.t   = $time + 4 * PERIOD;
        scoreQ.push_back(e);
        @(negedge clk);
        if (!holdGo) bus.go = 1'b0;
        @(negedge clk);
        if (late) begin
            bus.in1 = a + 4'(1 + $urandom_range(0, 14));
            bus.go  = 1'b1;
        end
        @(negedge clk);
        if (late) begin
            bus.in2 = b + 4'(1 + $urandom_range(0, 14));
            bus.go  = 1'b0;
        end
        @(negedge clk);
        if (late) bus.op = o + 2'(1 + $urandom_range(0, 2));
        @(negedge clk);
    endtask

    // Launches an operation and pulls reset while it sits in DECODE
    task automatic resetMidOp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        bus.in1 = a;
        bus.in2 = b;
        bus.op  = o;
        bus.go  = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midreset_in_decode", int'(bus.CS), 3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_cs", int'(bus.CS), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_stays_idle", int'(bus.CS), 0);
    endtask

    // Monitor: every done pops one expectation; outside done the output
    // must read 0 and the FSM must not sit in an execute state.
    always @(negedge clk) begin
        if (monEnable) begin
            if (bus.done === 1'b1) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    monEntry = scoreQ.pop_front();
                    checkOutput("result", int'(bus.out), monEntry.res);
                    checkOutput("exec_cs", int'(bus.CS), monEntry.cs);
                    checkOutput("done_time_offset", int'($time - monEntry.t), 0);
                end
            end else begin
                checkOutput("idle_out", int'(bus.out), 0);
                checkOutput("done_low_state", int'(bus.CS >= 3'd4), 0);
            end
        end
    end

    // Main stimulus sequence
    initial begin
        int waitCycles;
        checkCount = 0;
        errorCount = 0;
        monEnable  = 1'b0;
        rst_n      = 1'b0;
        bus.go     = 1'b0;
        bus.op     = 2'b00;
        bus.in1    = 4'd0;
        bus.in2    = 4'd0;

        repeat (2) @(negedge clk);
        monEnable = 1'b1;
        checkOutput("reset_cs", int'(bus.CS), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_out", int'(bus.out), 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("idle_cs", int'(bus.CS), 0);
        end

        // Directed cases including wrap-around boundaries
        applyStimulus(4'd3, 4'd5, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd2, 4'd7, 2'b01, 1'b0, 1'b0);
        applyStimulus(4'd15, 4'd1, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'd0, 4'd1, 2'b01, 1'b0, 1'b0);
        applyStimulus(4'b1100, 4'b1010, 2'b10, 1'b0, 1'b0);
        applyStimulus(4'b1100, 4'b1010, 2'b11, 1'b0, 1'b0);
        applyStimulus(4'd15, 4'd15, 2'b00, 1'b0, 1'b0);

        // Inputs and go disturbed after capture
        applyStimulus(4'd9, 4'd6, 2'b01, 1'b1, 1'b0);
        applyStimulus(4'd7, 4'd13, 2'b11, 1'b1, 1'b0);

        // Reset while in DECODE must cancel the operation
        resetMidOp(4'd5, 4'd5, 2'b00);

        // go held high: a done every five cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 1'b0, (i < 3));
        end

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Drain the scoreboard with a bounded wait
        waitCycles = 0;
        while (scoreQ.size() != 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("pending_results", scoreQ.size(), 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
